// File: rtl/text_console_ctrl.sv
// Terminal-style sequencer in front of a text-mode character RAM: turns one character per CPU put
// into cell writes, with cursor tracking, control codes, hardware scroll and clear.
`timescale 1ns/1ps
module text_console_ctrl #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 60,
    parameter logic [7:0]  ATTR = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_dat_i,
    output logic [31:0] cpu_dat_o,
    output logic        cpu_ack,
    output logic        busy,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        vc_stb,
    output logic        vc_we,
    output logic [31:0] vc_addr,
    output logic [31:0] vc_dat_o,
    input  logic [31:0] vc_dat_i,
    input  logic        vc_ack
);
    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StDecode  = 4'd1;
    localparam logic [3:0] StWr      = 4'd2;
    localparam logic [3:0] StWrWait  = 4'd3;
    localparam logic [3:0] StScrRd   = 4'd4;
    localparam logic [3:0] StScrWr   = 4'd5;
    localparam logic [3:0] StScrWait = 4'd6;
    localparam logic [3:0] StClrWr   = 4'd7;
    localparam logic [3:0] StClrWait = 4'd8;

    localparam logic [12:0] Cols13   = 13'(COLS);
    localparam logic [12:0] LastCell = 13'(COLS * ROWS - 1);
    localparam logic [12:0] LastRow  = 13'((ROWS - 1) * COLS);
    localparam logic [6:0]  LastX    = 7'(COLS - 1);
    localparam logic [5:0]  LastY    = 6'(ROWS - 1);
    localparam logic [15:0] Blank    = {ATTR, 8'h20};

    logic [3:0]  state_q, state_d;
    logic [7:0]  char_q, char_d;
    logic [6:0]  x_q, x_d;
    logic [5:0]  y_q, y_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic [31:0] stat_q, stat_d;
    logic        stb_q, stb_d;
    logic [12:0] addr_q, addr_d;
    logic [15:0] dat_q, dat_d;
    logic [12:0] cnt_q, cnt_d;
    logic        scroll_q, scroll_d;
    logic [12:0] cell_idx;
    logic        unused_vc_hi;

    assign cell_idx     = 13'(y_q) * Cols13 + 13'(x_q);
    assign unused_vc_hi = ^vc_dat_i[31:16];

    always_comb begin
        state_d  = state_q;
        char_d   = char_q;
        x_d      = x_q;
        y_d      = y_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        stat_d   = stat_q;
        stb_d    = stb_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        cnt_d    = cnt_q;
        scroll_d = scroll_q;

        // Status reads are served in every state; the ack_q guard keeps acks one cycle wide.
        if (cpu_stb && !cpu_we && !ack_q) begin
            ack_d  = 1'b1;
            stat_d = {busy_q, 15'b0, 8'(y_q), 8'(x_q)};
        end

        case (state_q)
            StIdle: begin
                if (cpu_stb && cpu_we && !ack_q) begin
                    char_d  = cpu_dat_i;
                    busy_d  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (char_q >= 8'h20 && char_q <= 8'h7E) begin
                    addr_d  = cell_idx;
                    dat_d   = {ATTR, char_q};
                    busy_d  = 1'b1;
                    state_d = StWr;
                    if (x_q == LastX) begin
                        x_d = 7'd0;
                        if (y_q == LastY) scroll_d = 1'b1;
                        else              y_d = y_q + 6'd1;
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                end else begin
                    case (char_q)
                        8'h0A: begin
                            x_d = 7'd0;
                            if (y_q == LastY) begin
                                busy_d  = 1'b1;
                                cnt_d   = Cols13;
                                addr_d  = Cols13;
                                state_d = StScrRd;
                            end else begin
                                y_d = y_q + 6'd1;
                            end
                        end
                        8'h0D: x_d = 7'd0;
                        8'h08: begin
                            if (x_q != 7'd0) begin
                                x_d     = x_q - 7'd1;
                                addr_d  = cell_idx - 13'd1;
                                dat_d   = Blank;
                                busy_d  = 1'b1;
                                state_d = StWr;
                            end
                        end
                        8'h0C: begin
                            x_d     = 7'd0;
                            y_d     = 6'd0;
                            cnt_d   = 13'd0;
                            busy_d  = 1'b1;
                            state_d = StClrWr;
                        end
                        default: ;
                    endcase
                end
            end
            // A still-high ack here is the stale one from the previous write.
            StWr: begin
                if (!vc_ack) begin
                    stb_d   = 1'b1;
                    state_d = StWrWait;
                end
            end
            StWrWait: begin
                if (vc_ack) begin
                    stb_d = 1'b0;
                    if (scroll_q) begin
                        scroll_d = 1'b0;
                        cnt_d    = Cols13;
                        addr_d   = Cols13;
                        state_d  = StScrRd;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            StScrRd: begin
                dat_d   = vc_dat_i[15:0];
                addr_d  = addr_q - Cols13;
                state_d = StScrWr;
            end
            StScrWr: begin
                if (!vc_ack) begin
                    stb_d   = 1'b1;
                    state_d = StScrWait;
                end
            end
            StScrWait: begin
                if (vc_ack) begin
                    stb_d = 1'b0;
                    if (cnt_q == LastCell) begin
                        cnt_d   = LastRow;
                        state_d = StClrWr;
                    end else begin
                        cnt_d   = cnt_q + 13'd1;
                        addr_d  = cnt_q + 13'd1;
                        state_d = StScrRd;
                    end
                end
            end
            StClrWr: begin
                addr_d = cnt_q;
                dat_d  = Blank;
                if (!vc_ack) begin
                    stb_d   = 1'b1;
                    state_d = StClrWait;
                end
            end
            StClrWait: begin
                if (vc_ack) begin
                    stb_d = 1'b0;
                    if (cnt_q == LastCell) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q + 13'd1;
                        state_d = StClrWr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            char_q   <= 8'h00;
            x_q      <= 7'd0;
            y_q      <= 6'd0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            stat_q   <= 32'h0;
            stb_q    <= 1'b0;
            addr_q   <= 13'd0;
            dat_q    <= 16'h0;
            cnt_q    <= 13'd0;
            scroll_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            char_q   <= char_d;
            x_q      <= x_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            stat_q   <= stat_d;
            stb_q    <= stb_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            cnt_q    <= cnt_d;
            scroll_q <= scroll_d;
        end
    end

    assign cpu_ack   = ack_q;
    assign cpu_dat_o = stat_q;
    assign busy      = busy_q;
    assign cursor_x  = x_q;
    assign cursor_y  = y_q;
    assign vc_stb    = stb_q;
    assign vc_we     = stb_q;
    assign vc_addr   = {19'b0, addr_q};
    assign vc_dat_o  = {16'h0, dat_q};

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: a 4x3 screen against a small character-RAM model,
// plus a default-size instance for the end-of-row wrap.
`timescale 1ns/1ps
module tb_text_console_ctrl;
    localparam int unsigned COLS = 4;
    localparam int unsigned ROWS = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        cpu_stb, cpu_we, cpu_ack, busy, vc_stb, vc_we;
    logic [7:0]  cpu_dat_i;
    logic [31:0] cpu_dat_o, vc_addr, vc_dat_o, vc_dat_i;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        card_ack = 1'b0;

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .ATTR(8'h00)) dut (
        .clk(clk), .reset(reset), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_dat_i(cpu_dat_i),
        .cpu_dat_o(cpu_dat_o), .cpu_ack(cpu_ack), .busy(busy), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .vc_stb(vc_stb), .vc_we(vc_we), .vc_addr(vc_addr),
        .vc_dat_o(vc_dat_o), .vc_dat_i(vc_dat_i), .vc_ack(card_ack)
    );

    // Character RAM model: registered ack, combinational read.
    logic [15:0] mem [16] = '{default: 16'h0};
    int          nwr = 0;
    logic [12:0] last_addr = 13'd0;
    logic [15:0] last_data = 16'h0;
    assign vc_dat_i = {16'h0, mem[vc_addr[3:0]]};

    always @(posedge clk) begin
        card_ack <= vc_stb & vc_we;
        if (vc_stb && vc_we) mem[vc_addr[3:0]] <= vc_dat_o[15:0];
        if (vc_stb && vc_we && card_ack) begin
            nwr       <= nwr + 1;
            last_addr <= vc_addr[12:0];
            last_data <= vc_dat_o[15:0];
        end
    end

    // Default-size instance, only its cursor is observed.
    logic        s2_stb, s2_we, s2_ack, s2_busy, s2_vstb, s2_vwe;
    logic [7:0]  s2_dat_i;
    logic [31:0] s2_dat_o, s2_vaddr, s2_vdat_o;
    logic [6:0]  s2_x;
    logic [5:0]  s2_y;
    logic        s2_card_ack = 1'b0;

    text_console_ctrl dut2 (
        .clk(clk), .reset(reset), .cpu_stb(s2_stb), .cpu_we(s2_we), .cpu_dat_i(s2_dat_i),
        .cpu_dat_o(s2_dat_o), .cpu_ack(s2_ack), .busy(s2_busy), .cursor_x(s2_x),
        .cursor_y(s2_y), .vc_stb(s2_vstb), .vc_we(s2_vwe), .vc_addr(s2_vaddr),
        .vc_dat_o(s2_vdat_o), .vc_dat_i(32'h0), .vc_ack(s2_card_ack)
    );
    always @(posedge clk) s2_card_ack <= s2_vstb & s2_vwe;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_screen(input string tag, input logic [15:0] e [12]);
        for (int k = 0; k < 12; k++)
            check($sformatf("%s cell%0d", tag, k), {16'h0, mem[k]}, {16'h0, e[k]});
    endtask

    task automatic put(input logic [7:0] c, output logic busy_at_ack, output logic ok);
        int n;
        cpu_dat_i = c;
        cpu_we    = 1'b1;
        cpu_stb   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cpu_ack && n < 50) begin @(negedge clk); n++; end
        busy_at_ack = busy;
        ok          = cpu_ack;
        cpu_stb     = 1'b0;
        cpu_we      = 1'b0;
        n = 0;
        while (busy && n < 500) begin @(negedge clk); n++; end
        if (busy) ok = 1'b0;
    endtask

    task automatic put2(input logic [7:0] c, output logic ok);
        int n;
        s2_dat_i = c;
        s2_we    = 1'b1;
        s2_stb   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s2_ack && n < 50) begin @(negedge clk); n++; end
        ok     = s2_ack;
        s2_stb = 1'b0;
        s2_we  = 1'b0;
        n = 0;
        while (s2_busy && n < 500) begin @(negedge clk); n++; end
        if (s2_busy) ok = 1'b0;
    endtask

    typedef struct {
        logic [7:0] ch;
        int         x;
        int         y;
        int         nw;
        int         addr;
        int         data;
    } vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t        vecs [17];
        logic [15:0] exp_scr [12];
        logic        bsy, ok, second;
        logic [31:0] st;
        int          n0, n;
        logic        idle_seen, acked;

        vecs[0]  = '{8'h41, 1, 0, 1, 0, 'h0041};
        vecs[1]  = '{8'h42, 2, 0, 1, 1, 'h0042};
        vecs[2]  = '{8'h43, 3, 0, 1, 2, 'h0043};
        vecs[3]  = '{8'h44, 0, 1, 1, 3, 'h0044};
        vecs[4]  = '{8'h07, 0, 1, 0, 0, 0};
        vecs[5]  = '{8'h08, 0, 1, 0, 0, 0};
        vecs[6]  = '{8'h45, 1, 1, 1, 4, 'h0045};
        vecs[7]  = '{8'h46, 2, 1, 1, 5, 'h0046};
        vecs[8]  = '{8'h08, 1, 1, 1, 5, 'h0020};
        vecs[9]  = '{8'h0D, 0, 1, 0, 0, 0};
        vecs[10] = '{8'h0A, 0, 2, 0, 0, 0};
        vecs[11] = '{8'h47, 1, 2, 1, 8, 'h0047};
        vecs[12] = '{8'h48, 2, 2, 1, 9, 'h0048};
        vecs[13] = '{8'h49, 3, 2, 1, 10, 'h0049};
        vecs[14] = '{8'h5A, 0, 2, 13, 11, 'h0020};
        vecs[15] = '{8'h0A, 0, 2, 12, 11, 'h0020};
        vecs[16] = '{8'h51, 1, 2, 1, 8, 'h0051};

        cpu_stb = 1'b0; cpu_we = 1'b0; cpu_dat_i = 8'h00;
        s2_stb = 1'b0; s2_we = 1'b0; s2_dat_i = 8'h00;

        repeat (3) @(negedge clk);
        check("rst cpu_ack", {31'b0, cpu_ack}, 32'h0);
        check("rst busy", {31'b0, busy}, 32'h0);
        check("rst vc_stb", {31'b0, vc_stb}, 32'h0);
        check("rst vc_we", {31'b0, vc_we}, 32'h0);
        check("rst vc_addr", vc_addr, 32'h0);
        check("rst vc_dat_o", vc_dat_o, 32'h0);
        check("rst cpu_dat_o", cpu_dat_o, 32'h0);
        check("rst cursor_x", {25'b0, cursor_x}, 32'h0);
        check("rst cursor_y", {26'b0, cursor_y}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            n0 = nwr;
            put(vecs[i].ch, bsy, ok);
            check($sformatf("v%0d handshake", i), {31'b0, ok}, 32'h1);
            check($sformatf("v%0d busy at ack", i), {31'b0, bsy}, 32'h1);
            check($sformatf("v%0d cursor_x", i), {25'b0, cursor_x}, vecs[i].x);
            check($sformatf("v%0d cursor_y", i), {26'b0, cursor_y}, vecs[i].y);
            check($sformatf("v%0d writes", i), nwr - n0, vecs[i].nw);
            if (vecs[i].nw > 0) begin
                check($sformatf("v%0d last addr", i), {19'b0, last_addr}, vecs[i].addr);
                check($sformatf("v%0d last data", i), {16'h0, last_data}, vecs[i].data);
            end
            if (i == 3) begin
                // Status read held one extra cycle: value in the ack cycle, no second ack.
                cpu_we = 1'b0; cpu_stb = 1'b1; n = 0;
                @(negedge clk);
                while (!cpu_ack && n < 20) begin @(negedge clk); n++; end
                st = cpu_dat_o;
                ok = cpu_ack;
                @(negedge clk);
                second  = cpu_ack;
                cpu_stb = 1'b0;
                check("status ack", {31'b0, ok}, 32'h1);
                check("status value", st, 32'h0000_0100);
                check("status ack single", {31'b0, second}, 32'h0);
            end
            if (i == 14) begin
                exp_scr = '{16'h0045, 16'h0020, 16'h0000, 16'h0000, 16'h0047, 16'h0048,
                            16'h0049, 16'h005A, 16'h0020, 16'h0020, 16'h0020, 16'h0020};
                check_screen("scroll1", exp_scr);
            end
        end
        exp_scr = '{16'h0047, 16'h0048, 16'h0049, 16'h005A, 16'h0020, 16'h0020,
                    16'h0020, 16'h0020, 16'h0051, 16'h0020, 16'h0020, 16'h0020};
        check_screen("scroll2", exp_scr);

        // FF from (1,2) with a second put held on the bus while the clear runs.
        n0 = nwr;
        cpu_dat_i = 8'h0C; cpu_we = 1'b1; cpu_stb = 1'b1; n = 0;
        @(negedge clk);
        while (!cpu_ack && n < 20) begin @(negedge clk); n++; end
        check("ff ack", {31'b0, cpu_ack}, 32'h1);
        cpu_dat_i = 8'h4B;
        idle_seen = 1'b0; acked = 1'b0; n = 0;
        while (!acked && n < 500) begin
            @(negedge clk); n++;
            if (cpu_ack) acked = 1'b1;
            else if (!busy) idle_seen = 1'b1;
        end
        check("held put acked", {31'b0, acked}, 32'h1);
        check("held put after idle", {31'b0, idle_seen}, 32'h1);
        check("ff clear writes", nwr - n0, 12);
        cpu_stb = 1'b0; cpu_we = 1'b0; n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        check("held put done", {31'b0, busy}, 32'h0);
        check("after ff cursor_x", {25'b0, cursor_x}, 32'd1);
        check("after ff cursor_y", {26'b0, cursor_y}, 32'd0);
        check("after ff writes", nwr - n0, 13);
        exp_scr = '{16'h004B, 16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020,
                    16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020};
        check_screen("clear", exp_scr);

        // Reset asserted in the middle of a scroll.
        put(8'h0A, bsy, ok);
        put(8'h0A, bsy, ok);
        check("pre-scroll cursor_y", {26'b0, cursor_y}, 32'd2);
        cpu_dat_i = 8'h0A; cpu_we = 1'b1; cpu_stb = 1'b1; n = 0;
        @(negedge clk);
        while (!cpu_ack && n < 20) begin @(negedge clk); n++; end
        cpu_stb = 1'b0; cpu_we = 1'b0;
        repeat (10) @(negedge clk);
        check("scroll in progress", {31'b0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        check("abort vc_stb", {31'b0, vc_stb}, 32'h0);
        check("abort busy", {31'b0, busy}, 32'h0);
        check("abort cursor_x", {25'b0, cursor_x}, 32'd0);
        check("abort cursor_y", {26'b0, cursor_y}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n0 = nwr;
        put(8'h41, bsy, ok);
        check("post-reset put", {31'b0, ok}, 32'h1);
        check("post-reset addr", {19'b0, last_addr}, 32'd0);
        check("post-reset cursor_x", {25'b0, cursor_x}, 32'd1);

        // Default 80-column instance: wrap at column 79.
        for (int i = 0; i < 79; i++) put2(8'h41, ok);
        check("dflt cursor_x at 79", {25'b0, s2_x}, 32'd79);
        check("dflt cursor_y at 79", {26'b0, s2_y}, 32'd0);
        put2(8'h41, ok);
        check("dflt wrap handshake", {31'b0, ok}, 32'h1);
        check("dflt wrap cursor_x", {25'b0, s2_x}, 32'd0);
        check("dflt wrap cursor_y", {26'b0, s2_y}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
